fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter stage that sits directly upstream of the 64-bit ripple adders in the single-cycle ARM datapath.
- Holds the architectural PC and produces PC+4 and branch targets (PC + imm<<2, or a register value for BR).
- Presents the current fetch address to the decode/instruction-memory side through a valid/ready handshake.
- Handles redirects, stalls, misaligned-target faults and a retired-fetch counter.

Parameters:
WIDTH, 64, address/data width of PC and targets
RESET_PC, 64'h0, PC value loaded on reset
CNT_W, 32, width of fetch counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
if_ready  input  1  downstream accepts current PC this cycle
redirect_valid  input  1  branch/jump resolved taken this cycle
redirect_is_reg  input  1  1: target = redirect_reg (BR); 0: PC-relative
redirect_reg  input  WIDTH  absolute register target
redirect_imm  input  WIDTH  sign-extended word offset (shifted left 2 internally)
pc  output  WIDTH  current fetch address
pc_plus4  output  WIDTH  pc + 4, combinational from pc
if_valid  output  1  pc is a valid fetch request
fault  output  1  misaligned redirect target detected, sticky
fetch_count  output  CNT_W  number of accepted fetches

Behaviour:
- Reset:
  - Asynchronous on reset_n low: pc=RESET_PC, if_valid=0, fault=0, fetch_count=0, state=BOOT.
  - Reset asserted mid-operation discards any pending redirect and counter value immediately.
- States: BOOT, RUN, FAULT.
  - BOOT: first rising edge with reset_n high -> RUN, if_valid=1. pc stays RESET_PC.
  - RUN: if_valid=1. Accept = if_valid & if_ready.
  - FAULT: if_valid=0, fault=1, pc frozen, all inputs ignored. Exits only by reset.
- Next-PC priority in RUN, evaluated at each rising edge:
  1. redirect_valid=1:
     - target = redirect_is_reg ? redirect_reg : pc + (redirect_imm<<2).
     - If target[1:0]!=0: state->FAULT and pc unchanged. Otherwise pc<=target.
     - Redirect applies whether or not if_ready is high, which flushes a stalled fetch.
     - fetch_count increments only if accept was also true that cycle.
  2. else if accept: pc<=pc+4, fetch_count+=1.
  3. else (stall): pc, fetch_count hold.
- Arithmetic:
  - All PC arithmetic is modulo 2^WIDTH; carry out is discarded. pc=64'hFFFF_FFFF_FFFF_FFFC with accept wraps to 0.
  - redirect_imm<<2 discards the top 2 bits.
  - fetch_count wraps at 2^CNT_W.
- pc_plus4 is purely combinational: pc+4, no added latency.
- Latency: redirect or accept at edge N is visible on pc after edge N. No bubble is inserted; if_valid stays 1 across redirects.
- if_valid must not depend combinationally on if_ready.
- A redirect_is_reg target only checks alignment; no range check.

Test Plan:
- Reset with RESET_PC=64'h100, release, if_ready=1 for 4 cycles -> pc shows 0x100 (if_valid rises the cycle after release), then 0x104, 0x108, 0x10C; fetch_count=3 after the third accept.
- pc=0x200, if_ready=0 for 3 cycles -> pc holds 0x200, if_valid=1, fetch_count unchanged; then if_ready=1 -> pc=0x204.
- pc=0x300, redirect_valid=1, is_reg=0, imm=-2 (all-ones minus 1), if_ready=0 -> next pc=0x2F8; fetch_count unchanged.
- pc=0x400, redirect_valid=1, is_reg=1, reg=0x1002 -> fault=1, if_valid=0, pc stays 0x400; further redirects ignored; reset_n low clears fault.
- pc=64'hFFFF_FFFF_FFFF_FFFC, accept -> pc=0, pc_plus4=4; CNT_W=2 with 5 accepts -> fetch_count=1.
- Assert reset_n low asynchronously mid-cycle during a redirect -> pc=RESET_PC and if_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch-address handshake and redirect bus between PC stage and decode
interface fetch_pc_unit_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
);
    logic             if_ready;
    logic             redirect_valid;
    logic             redirect_is_reg;
    logic [WIDTH-1:0] redirect_reg;
    logic [WIDTH-1:0] redirect_imm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             if_valid;
    logic             fault;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  if_ready, redirect_valid, redirect_is_reg, redirect_reg, redirect_imm,
        output pc, pc_plus4, if_valid, fault, fetch_count
    );

    modport slave (
        output if_ready, redirect_valid, redirect_is_reg, redirect_reg, redirect_imm,
        input  pc, pc_plus4, if_valid, fault, fetch_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter stage with redirect, stall, misalignment fault and fetch counter
module fetch_pc_unit #(
    parameter int              WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    fetch_pc_unit_if.master   bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] target;
    logic             target_misaligned;
    logic             accept;
    logic             valid_o;
    logic             fault_o;

    // Shifting the full-width imm drops its top two bits, giving the modulo word offset.
    assign target            = bus.redirect_is_reg ? bus.redirect_reg
                                                   : pc_q + (bus.redirect_imm << 2);
    assign target_misaligned = (target[1:0] != 2'b00);
    assign accept            = valid_o & bus.if_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.redirect_valid && target_misaligned) state_d = FAULT;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    // Registered-state decode only, so if_valid never sees if_ready combinationally.
    always_comb begin
        valid_o = 1'b0;
        fault_o = 1'b0;
        case (state_q)
            RUN:     valid_o = 1'b1;
            FAULT:   fault_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (state_q == RUN) begin
            if (bus.redirect_valid) begin
                if (!target_misaligned) begin
                    pc_d = target;
                end
                if (accept) begin
                    cnt_d = cnt_q + CNT_STEP;
                end
            end else if (accept) begin
                pc_d  = pc_q + PC_STEP;
                cnt_d = cnt_q + CNT_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + PC_STEP;
    assign bus.if_valid    = valid_o;
    assign bus.fault       = fault_o;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed table-driven bench for fetch_pc_unit
module tb_fetch_pc_unit;
    localparam int              WIDTH    = 64;
    localparam int              CNT_W    = 2;
    localparam logic [WIDTH-1:0] RST_PC  = 64'h100;

    logic clk;
    logic reset_n;

    fetch_pc_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fetch_pc_unit #(.WIDTH(WIDTH), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             ready;
        logic             rv;
        logic             is_reg;
        logic [WIDTH-1:0] rreg;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] exp_pc;
        logic [WIDTH-1:0] exp_plus4;
        logic             exp_valid;
        logic             exp_fault;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] p, input logic v,
                             input logic f, input logic [CNT_W-1:0] c);
        check({tag, " pc"},    bus.pc, p);
        check({tag, " valid"}, WIDTH'(bus.if_valid), WIDTH'(v));
        check({tag, " fault"}, WIDTH'(bus.fault), WIDTH'(f));
        check({tag, " cnt"},   WIDTH'(bus.fetch_count), WIDTH'(c));
    endtask

    task automatic drive(input logic r, input logic rv, input logic ir,
                         input logic [WIDTH-1:0] rr, input logic [WIDTH-1:0] im);
        bus.if_ready        = r;
        bus.redirect_valid  = rv;
        bus.redirect_is_reg = ir;
        bus.redirect_reg    = rr;
        bus.redirect_imm    = im;
    endtask

    task automatic add(input logic r, input logic rv, input logic ir, input logic [WIDTH-1:0] rr,
                       input logic [WIDTH-1:0] im, input logic [WIDTH-1:0] ep, input logic ev,
                       input logic ef, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.ready = r; v.rv = rv; v.is_reg = ir; v.rreg = rr; v.imm = im;
        v.exp_pc = ep; v.exp_plus4 = ep + 64'd4; v.exp_valid = ev; v.exp_fault = ef; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        //  ready rv ir reg                     imm                      exp_pc                  v  f  cnt
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h100,                1, 0, 2'd0); // boot
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h104,                1, 0, 2'd1);
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h108,                1, 0, 2'd2);
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h10C,                1, 0, 2'd3);
        add(0, 1, 1, 64'h200,                64'h0,                   64'h200,                1, 0, 2'd3);
        add(0, 0, 0, 64'h0,                  64'h0,                   64'h200,                1, 0, 2'd3);
        add(0, 0, 0, 64'h0,                  64'h0,                   64'h200,                1, 0, 2'd3);
        add(0, 0, 0, 64'h0,                  64'h0,                   64'h200,                1, 0, 2'd3);
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h204,                1, 0, 2'd0); // 2-bit wrap
        add(1, 1, 1, 64'h300,                64'h0,                   64'h300,                1, 0, 2'd1);
        add(0, 1, 0, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFE, 64'h2F8,                1, 0, 2'd1);
        add(1, 1, 0, 64'h0,                  64'h4,                   64'h308,                1, 0, 2'd2);
        add(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 2'd2);
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h0,                  1, 0, 2'd3);
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h4,                  1, 0, 2'd0);
        add(0, 1, 0, 64'h0,                  64'h4000_0000_0000_0001, 64'h8,                  1, 0, 2'd0);
        add(0, 1, 1, 64'h400,                64'h0,                   64'h400,                1, 0, 2'd0);
        add(0, 1, 1, 64'h1002,               64'h0,                   64'h400,                0, 1, 2'd0); // misaligned
        add(1, 1, 1, 64'h800,                64'h0,                   64'h400,                0, 1, 2'd0);
        add(1, 0, 0, 64'h0,                  64'h0,                   64'h400,                0, 1, 2'd0);

        reset_n = 1'b0;
        drive(0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1 check_all("reset", RST_PC, 1'b0, 1'b0, 2'd0);
        check("reset plus4", bus.pc_plus4, RST_PC + 64'd4);

        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ready, vecs[i].rv, vecs[i].is_reg, vecs[i].rreg, vecs[i].imm);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                      vecs[i].exp_fault, vecs[i].exp_cnt);
            check($sformatf("vec%0d plus4", i), bus.pc_plus4, vecs[i].exp_plus4);
            @(negedge clk);
        end

        // Reset clears the sticky fault without a clock edge.
        drive(0, 0, 0, '0, '0);
        reset_n = 1'b0;
        #1 check_all("fault clear", RST_PC, 1'b0, 1'b0, 2'd0);

        // Build up some state, then reset mid-cycle after a redirect edge.
        @(negedge clk) reset_n = 1'b1;
        drive(1, 0, 0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 check_all("pre redirect", 64'h104, 1'b1, 1'b0, 2'd1);
        @(negedge clk) drive(1, 1, 1, 64'h500, '0);
        @(posedge clk);
        #1 check_all("redirect taken", 64'h500, 1'b1, 1'b0, 2'd2);
        #2 reset_n = 1'b0;
        #1 check_all("async mid", RST_PC, 1'b0, 1'b0, 2'd0);

        // Pending redirect dropped by reset asserted before its edge.
        @(negedge clk) reset_n = 1'b1;
        drive(1, 0, 0, '0, '0);
        @(posedge clk);
        @(negedge clk) drive(1, 1, 1, 64'h600, '0);
        #1 reset_n = 1'b0;
        #1 check_all("pending drop", RST_PC, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1 check_all("held in reset", RST_PC, 1'b0, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
